rvv_backend_rob_wb_collect: RTL

//  Receiving end of the ALU->ROB write-back interface. Captures per-cycle ALU2ROB_t

---
 rtl/rvv_backend_rob_wb_collect.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rvv_backend_rob_wb_collect.sv
// ALU->ROB write-back collector: per-ALU result FIFOs with no input backpressure,
// drained one entry per cycle through a round-robin arbiter onto one ROB write port.
module rvv_backend_rob_wb_collect #(
   parameter  int NUM_ALU     = 2,
   parameter  int FIFO_DEPTH  = 4,
   parameter  int AFULL_LVL   = 2,
   parameter  int DATA_W      = 32,
   parameter  int ROB_ENTRY_W = 5,
   localparam int PAY_W       = DATA_W + ROB_ENTRY_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_ALU-1:0]       result_valid_ex2rob,
   input  logic [NUM_ALU*PAY_W-1:0] result_ex2rob,
   input  logic                     rob_flush,
   output logic                     wr_valid_wb2rob,
   output logic [PAY_W-1:0]         wr_data_wb2rob,
   input  logic                     wr_ready_rob2wb,
   output logic [NUM_ALU-1:0]       almost_full_wb2rs,
   output logic                     overflow_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int GNT_W = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;

   logic [PAY_W-1:0] mem_q    [NUM_ALU][FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q [NUM_ALU];
   logic [PTR_W-1:0] rd_ptr_d [NUM_ALU];
   logic [PTR_W-1:0] wr_ptr_q [NUM_ALU];
   logic [PTR_W-1:0] wr_ptr_d [NUM_ALU];
   logic [CNT_W-1:0] count_q  [NUM_ALU];
   logic [CNT_W-1:0] count_d  [NUM_ALU];

   logic [GNT_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [GNT_W-1:0]   lock_gnt_q, lock_gnt_d;
   logic               lock_q, lock_d;
   logic               ovf_q, ovf_d;
   logic [NUM_ALU-1:0] afull_q, afull_d;

   logic [NUM_ALU-1:0] not_empty, push, pop, drop, wr_en;
   logic [GNT_W-1:0]   grant;
   logic               found;
   int unsigned        arb_idx;
   logic               xfer;

   // Arbitration: a stalled grant is held so the presented payload cannot change under the ROB.
   always_comb begin
      grant   = rr_ptr_q;
      found   = 1'b0;
      arb_idx = 0;
      for (int p = 0; p < NUM_ALU; p++) begin
         not_empty[p] = (count_q[p] != '0);
      end
      if (lock_q) begin
         grant = lock_gnt_q;
         found = 1'b1;
      end
      for (int i = 0; i < NUM_ALU; i++) begin
         arb_idx = (int'(rr_ptr_q) + i) % NUM_ALU;
         if (!found && not_empty[arb_idx]) begin
            grant = GNT_W'(arb_idx);
            found = 1'b1;
         end
      end
   end

   assign wr_valid_wb2rob   = |not_empty;
   assign wr_data_wb2rob    = wr_valid_wb2rob ? mem_q[grant][rd_ptr_q[grant]] : '0;
   assign xfer              = wr_valid_wb2rob & wr_ready_rob2wb;
   assign almost_full_wb2rs = afull_q;
   assign overflow_err      = ovf_q;

   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      lock_d     = wr_valid_wb2rob & ~wr_ready_rob2wb;
      lock_gnt_d = grant;
      ovf_d      = ovf_q;
      for (int p = 0; p < NUM_ALU; p++) begin
         pop[p]      = xfer && (grant == GNT_W'(p));
         push[p]     = result_valid_ex2rob[p] && !rob_flush;
         // A pop in the same cycle frees the slot, so a full FIFO can still accept.
         drop[p]     = push[p] && (count_q[p] == CNT_W'(FIFO_DEPTH)) && !pop[p];
         wr_en[p]    = push[p] && !drop[p];
         rd_ptr_d[p] = rd_ptr_q[p] + PTR_W'(pop[p]);
         wr_ptr_d[p] = wr_ptr_q[p] + PTR_W'(wr_en[p]);
         count_d[p]  = count_q[p] + CNT_W'(wr_en[p]) - CNT_W'(pop[p]);
         if (drop[p]) begin
            ovf_d = 1'b1;
         end
      end
      if (xfer) begin
         rr_ptr_d = (grant == GNT_W'(NUM_ALU - 1)) ? '0 : grant + GNT_W'(1);
      end
      if (rob_flush) begin
         rr_ptr_d = '0;
         lock_d   = 1'b0;
         for (int p = 0; p < NUM_ALU; p++) begin
            rd_ptr_d[p] = '0;
            wr_ptr_d[p] = '0;
            count_d[p]  = '0;
         end
      end
      for (int p = 0; p < NUM_ALU; p++) begin
         afull_d[p] = (CNT_W'(FIFO_DEPTH) - count_d[p]) <= CNT_W'(AFULL_LVL);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_gnt_q <= '0;
         ovf_q      <= 1'b0;
         afull_q    <= '0;
         for (int p = 0; p < NUM_ALU; p++) begin
            rd_ptr_q[p] <= '0;
            wr_ptr_q[p] <= '0;
            count_q[p]  <= '0;
         end
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         lock_q     <= lock_d;
         lock_gnt_q <= lock_gnt_d;
         ovf_q      <= ovf_d;
         afull_q    <= afull_d;
         for (int p = 0; p < NUM_ALU; p++) begin
            rd_ptr_q[p] <= rd_ptr_d[p];
            wr_ptr_q[p] <= wr_ptr_d[p];
            count_q[p]  <= count_d[p];
         end
      end
   end

   // Storage needs no reset: an entry is only visible while its count covers it.
   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_ALU; p++) begin
         if (wr_en[p]) begin
            mem_q[p][wr_ptr_q[p]] <= result_ex2rob[p*PAY_W +: PAY_W];
         end
      end
   end

`ifdef ASSERT_ON
   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_ALU; p++) begin
         if (!rst && drop[p]) begin
            $error("wb_collect overflow: port %0d dropped rob_entry %0d",
                   p, result_ex2rob[p*PAY_W +: ROB_ENTRY_W]);
         end
      end
   end
`endif

endmodule
